dm_mmio: RTL and testbench
==========================

# dm_mmio

Data-side memory block consumed by the single-cycle CPU core. It serves the core's data-memory port with a word RAM plus a small memory-mapped I/O page. The page holds an LED register, a free-running cycle counter and an 8-entry byte TX FIFO, which an external consumer drains through a valid/ready port. Reads are combinational so the core completes loads in its single cycle; all state updates occur on the rising clock edge.

## Interface

Parameters:
- RAM_AW, 10, RAM word-address width; RAM depth is 2**RAM_AW words.
- FIFO_AW, 3, TX FIFO address width; FIFO depth is 2**FIFO_AW entries.

Ports:
- inclk  in  1  clock; the same clock that drives the core's register file and data-memory writes.
- rst  in  1  synchronous, active-high reset.
- DM_CS  in  1  chip select; no access takes place when this is 0.
- DM_R  in  1  read enable.
- DM_W  in  1  write enable.
- i_DM_addr  in  32  byte address; bits [1:0] are ignored.
- i_DM_wdata  in  32  write data.
- o_DM_rdata  out  32  read data, combinational.
- o_led  out  16  LED register.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO is non-empty.
- tx_ready  in  1  the consumer accepts the head byte.

## Operation

Address map (word-aligned):
- RAM: 0x0000_0000 to 4*2**RAM_AW−1, indexed by addr[RAM_AW+1:2]; read/write.
- LED, 0xFFFF_0000: write sets wdata[15:0]; read returns {16'b0, led}.
- TXDATA, 0xFFFF_0004: write pushes wdata[7:0]; read returns 0.
- STATUS, 0xFFFF_0008: read returns bit0 empty, bit1 full, bit2 ovf (sticky), bits[11:8] count (0–8), other bits 0. A write with wdata[2]=1 clears ovf.
- CYCLE, 0xFFFF_000C: read returns the counter; a write loads wdata.
- Any other address: read returns 0; write is ignored.

Rules:
- A write is performed when DM_CS & DM_W is 1 at the edge.
- o_DM_rdata is 0 unless DM_CS & DM_R is 1. It always reflects pre-edge state, so a read together with a write to the same address returns the old value.
- Reads have no side effects.
- RAM is not cleared by reset; its contents are undefined until written. The bench initialises any RAM it reads.
- FIFO is a circular buffer with rd/wr pointers that wrap modulo depth, plus a count.
- Pop occurs when tx_valid & tx_ready.
- A push is accepted when count < depth or a pop happens in the same cycle.
- A push on a full FIFO with no pop in that cycle is dropped and sets ovf.
- A simultaneous push and pop leaves count unchanged; both pointers advance.
- tx_valid = (count != 0). tx_data = the head entry when valid, otherwise 0.
- The cycle counter increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0. In a cycle where CYCLE is written, it loads wdata instead of incrementing.
- ovf clear and ovf set in the same cycle: set wins.

## Timing

- Reset values: o_led=0, FIFO empty (count 0, pointers 0), ovf=0, cycle=0, tx_valid=0, tx_data=0. o_DM_rdata follows the combinational rules.
- The first cycle after rst deasserts reads CYCLE=0, then 1, 2, and so on.
- Write latency is one edge: a value written at edge N is readable, or visible on o_led, during cycle N+1.
- A push at edge N raises tx_valid in cycle N+1. A pop at edge N exposes the next entry, or drops tx_valid, in cycle N+1.
- tx_ready is sampled only at edges. tx_data must be held stable while tx_valid=1 and tx_ready=0.
- Reset asserted mid-operation discards FIFO contents and overflow state at that edge. RAM is untouched.

## Test plan

- Write RAM 0x0000_0010=0xDEADBEEF, then read 0x10 and 0x13 → both return 0xDEADBEEF. Read 0x10 with DM_CS=0 → 0.
- Write LED 0x1234_ABCD → o_led=0xABCD next cycle; read LED → 0x0000_ABCD; assert rst → o_led=0.
- Push 0x41,0x42,0x43 with tx_ready=0 → STATUS=0x0000_0300; then set tx_ready=1 → tx_data shows 0x41,0x42,0x43 on consecutive cycles, then tx_valid=0.
- Push 9 bytes with tx_ready=0 → count 8, full=1, ovf=1, 9th byte lost. Push with tx_ready=1 while full → accepted, count stays 8, ovf unchanged. Write STATUS 0x4 → ovf=0.
- Release reset → CYCLE reads 0,1,2. Write CYCLE=0xFFFF_FFFE → next reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Read 0x8000_0000 → 0. Write 0x8000_0000 → no RAM or register changes.

Source files
------------

// File: rtl/dm_mmio.sv
// dm_mmio: data-side memory for the single-cycle core.
// Holds a word RAM plus an MMIO page with an LED register, a free-running
// cycle counter and a byte TX FIFO drained through a valid/ready port.
// Reads are combinational; all state changes on the rising edge of inclk.
module dm_mmio #(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic        inclk,
    input  logic        rst,
    input  logic        DM_CS,
    input  logic        DM_R,
    input  logic        DM_W,
    input  logic [31:0] i_DM_addr,
    input  logic [31:0] i_DM_wdata,
    output logic [31:0] o_DM_rdata,
    output logic [15:0] o_led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned RAM_WORDS = 1 << RAM_AW;
    localparam int unsigned DEPTH     = 1 << FIFO_AW;
    localparam int unsigned CW        = FIFO_AW + 1;

    // Register state
    logic [31:0]        r_ram  [RAM_WORDS];
    logic [7:0]         r_fifo [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_ovf;
    logic [15:0]        r_led;
    logic [31:0]        r_cycle;

    // Access qualifiers and address decode
    logic               w_wr;
    logic               w_rd;
    logic               w_io_page;
    logic               w_sel_ram;
    logic               w_sel_led;
    logic               w_sel_tx;
    logic               w_sel_status;
    logic               w_sel_cycle;
    logic [RAM_AW-1:0]  w_ram_idx;

    // FIFO handshake terms
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_accept;
    logic               w_drop;
    logic               w_ovf_clr;
    logic               w_unused;

    assign w_wr         = DM_CS & DM_W;
    assign w_rd         = DM_CS & DM_R;
    assign w_io_page    = (i_DM_addr[31:4] == 28'hFFFF_000);
    assign w_sel_ram    = (i_DM_addr[31:RAM_AW+2] == '0);
    assign w_sel_led    = w_io_page & (i_DM_addr[3:2] == 2'd0);
    assign w_sel_tx     = w_io_page & (i_DM_addr[3:2] == 2'd1);
    assign w_sel_status = w_io_page & (i_DM_addr[3:2] == 2'd2);
    assign w_sel_cycle  = w_io_page & (i_DM_addr[3:2] == 2'd3);
    assign w_ram_idx    = i_DM_addr[RAM_AW+1:2];

    // Byte-offset bits never select anything
    assign w_unused     = &{1'b0, i_DM_addr[1:0]};

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = tx_valid & tx_ready;
    assign w_push    = w_wr & w_sel_tx;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_accept  = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & ~w_accept;
    assign w_ovf_clr = w_wr & w_sel_status & i_DM_wdata[2];

    assign tx_valid = ~w_empty;
    assign tx_data  = tx_valid ? r_fifo[r_rd_ptr] : 8'd0;
    assign o_led    = r_led;

    // RAM word write; contents are not affected by reset
    always_ff @(posedge inclk) begin
        if (w_wr && w_sel_ram) begin
            r_ram[w_ram_idx] <= i_DM_wdata;
        end
    end

    // FIFO storage write at the tail on an accepted push
    always_ff @(posedge inclk) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= i_DM_wdata[7:0];
        end
    end

    // Control registers: LED, cycle counter, FIFO pointers/count, sticky overflow
    always_ff @(posedge inclk) begin
        if (rst) begin
            r_led    <= '0;
            r_cycle  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr && w_sel_led) begin
                r_led <= i_DM_wdata[15:0];
            end

            if (w_wr && w_sel_cycle) begin
                r_cycle <= i_DM_wdata;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end

            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end

            if (w_accept && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - CW'(1);
            end

            // Overflow set takes priority over a same-cycle clear
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Combinational read mux over pre-edge state
    always_comb begin
        o_DM_rdata = 32'd0;
        if (w_rd) begin
            if (w_sel_ram) begin
                o_DM_rdata = r_ram[w_ram_idx];
            end else if (w_sel_led) begin
                o_DM_rdata = {16'd0, r_led};
            end else if (w_sel_status) begin
                o_DM_rdata = {20'd0, 4'(r_count), 5'd0, r_ovf, w_full, w_empty};
            end else if (w_sel_cycle) begin
                o_DM_rdata = r_cycle;
            end
        end
    end

endmodule

// File: tb/tb_dm_mmio.sv
// Directed self-checking bench for dm_mmio.
module tb_dm_mmio;

    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_TX     = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_000C;

    logic        inclk;
    logic        rst;
    logic        DM_CS;
    logic        DM_R;
    logic        DM_W;
    logic [31:0] i_DM_addr;
    logic [31:0] i_DM_wdata;
    logic [31:0] o_DM_rdata;
    logic [15:0] o_led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] rv;

    dm_mmio #(.RAM_AW(10), .FIFO_AW(3)) u_dut (
        .inclk      (inclk),
        .rst        (rst),
        .DM_CS      (DM_CS),
        .DM_R       (DM_R),
        .DM_W       (DM_W),
        .i_DM_addr  (i_DM_addr),
        .i_DM_wdata (i_DM_wdata),
        .o_DM_rdata (o_DM_rdata),
        .o_led      (o_led),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    // Count one comparison and report it if it differs
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it
    task automatic tick();
        @(posedge inclk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        DM_CS = 1'b1; DM_W = 1'b1; DM_R = 1'b0;
        i_DM_addr = a; i_DM_wdata = d;
        tick();
        DM_CS = 1'b0; DM_W = 1'b0;
    endtask

    // Combinational read within the current cycle, no clock advance
    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        DM_CS = 1'b1; DM_R = 1'b1; DM_W = 1'b0;
        i_DM_addr = a;
        #1;
        d = o_DM_rdata;
        DM_CS = 1'b0; DM_R = 1'b0;
    endtask

    initial begin
        rst = 1'b1; DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
        i_DM_addr = '0; i_DM_wdata = '0; tx_ready = 1'b0;
        tick(); tick();
        check("rst_led", 32'(o_led), 32'h0);
        check("rst_valid", 32'(tx_valid), 32'h0);
        check("rst_txdata", 32'(tx_data), 32'h0);
        rst = 1'b0;

        // Cycle counter after reset release
        rd(A_CYCLE, rv); check("cycle0", rv, 32'd0);
        tick(); rd(A_CYCLE, rv); check("cycle1", rv, 32'd1);
        tick(); rd(A_CYCLE, rv); check("cycle2", rv, 32'd2);
        rd(A_STATUS, rv); check("status_rst", rv, 32'h0000_0001);

        // RAM write/read, ignored byte bits, chip select gating
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, rv); check("ram_10", rv, 32'hDEAD_BEEF);
        rd(32'h0000_0013, rv); check("ram_13", rv, 32'hDEAD_BEEF);
        DM_CS = 1'b0; DM_R = 1'b1; i_DM_addr = 32'h0000_0010; #1;
        check("ram_nocs", o_DM_rdata, 32'h0);
        DM_R = 1'b0;
        wr(32'h0000_0000, 32'h0BAD_F00D);
        rd(32'h0000_0000, rv); check("ram_00", rv, 32'h0BAD_F00D);

        // Read together with write returns the old value
        DM_CS = 1'b1; DM_R = 1'b1; DM_W = 1'b1;
        i_DM_addr = 32'h0000_0010; i_DM_wdata = 32'h1111_1111; #1;
        check("ram_rdw_old", o_DM_rdata, 32'hDEAD_BEEF);
        tick();
        DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
        rd(32'h0000_0010, rv); check("ram_rdw_new", rv, 32'h1111_1111);

        // LED register
        wr(A_LED, 32'h1234_ABCD);
        check("led_out", 32'(o_led), 32'h0000_ABCD);
        rd(A_LED, rv); check("led_rd", rv, 32'h0000_ABCD);

        // FIFO: three pushes held, then drained
        wr(A_TX, 32'h41); wr(A_TX, 32'h42); wr(A_TX, 32'h43);
        rd(A_STATUS, rv); check("status_3", rv, 32'h0000_0300);
        rd(A_TX, rv); check("txdata_rd", rv, 32'h0);
        check("fifo_hold", 32'(tx_data), 32'h41);
        tx_ready = 1'b1;
        check("drain_41", 32'(tx_data), 32'h41);
        tick(); check("drain_42", 32'(tx_data), 32'h42);
        tick(); check("drain_43", 32'(tx_data), 32'h43);
        tick(); check("drain_valid0", 32'(tx_valid), 32'h0);
        check("drain_data0", 32'(tx_data), 32'h0);
        tx_ready = 1'b0;

        // Overflow: nine pushes into an eight-entry FIFO
        for (int i = 0; i < 9; i++) wr(A_TX, 32'h50 + 32'(i));
        rd(A_STATUS, rv); check("status_ovf", rv, 32'h0000_0806);
        check("ovf_head", 32'(tx_data), 32'h50);
        // Push while full with a pop in the same cycle is accepted
        tx_ready = 1'b1;
        wr(A_TX, 32'h77);
        tx_ready = 1'b0;
        rd(A_STATUS, rv); check("status_pushpop", rv, 32'h0000_0806);
        check("pushpop_head", 32'(tx_data), 32'h51);
        wr(A_STATUS, 32'h4);
        rd(A_STATUS, rv); check("status_ovfclr", rv, 32'h0000_0802);
        // Drain: 0x51..0x57 then 0x77; 0x58 was dropped
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_drain%0d", i), 32'(tx_data),
                  (i < 7) ? 32'h51 + 32'(i) : 32'h77);
            tick();
        end
        check("ovf_drain_empty", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // Overflow set wins over a same-cycle clear is not reachable in one
        // write; instead verify clear leaves empty status clean
        rd(A_STATUS, rv); check("status_empty", rv, 32'h0000_0001);

        // Cycle counter load and wrap
        wr(A_CYCLE, 32'hFFFF_FFFE);
        rd(A_CYCLE, rv); check("cyc_ld", rv, 32'hFFFF_FFFE);
        tick(); rd(A_CYCLE, rv); check("cyc_max", rv, 32'hFFFF_FFFF);
        tick(); rd(A_CYCLE, rv); check("cyc_wrap", rv, 32'h0);

        // Unmapped address
        rd(32'h8000_0000, rv); check("unmap_rd", rv, 32'h0);
        rd(32'hFFFF_0010, rv); check("unmap_rd_io", rv, 32'h0);
        wr(32'h8000_0000, 32'hCAFE_F00D);
        rd(32'h0000_0000, rv); check("unmap_ram0", rv, 32'h0BAD_F00D);
        rd(32'h0000_0010, rv); check("unmap_ram10", rv, 32'h1111_1111);
        check("unmap_led", 32'(o_led), 32'h0000_ABCD);
        rd(A_STATUS, rv); check("unmap_status", rv, 32'h0000_0001);

        // Mid-operation reset: FIFO, ovf, LED, counter cleared; RAM kept
        for (int i = 0; i < 9; i++) wr(A_TX, 32'h60 + 32'(i));
        rd(A_STATUS, rv); check("pre_rst_status", rv, 32'h0000_0806);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(tx_valid), 32'h0);
        check("mid_rst_led", 32'(o_led), 32'h0);
        rd(A_STATUS, rv); check("mid_rst_status", rv, 32'h0000_0001);
        rd(A_CYCLE, rv); check("mid_rst_cycle", rv, 32'h0);
        rd(32'h0000_0010, rv); check("mid_rst_ram", rv, 32'h1111_1111);

        // FIFO restarts cleanly after reset
        wr(A_TX, 32'hA5);
        check("post_rst_push", 32'(tx_data), 32'hA5);
        rd(A_STATUS, rv); check("post_rst_status", rv, 32'h0000_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
